// File: rtl/icache_dm_if.sv
// Core-side fetch port and memory-side line-fill handshake of the direct-mapped instruction cache.
interface icache_dm_if;
  logic         proc_read;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hits, stall-and-refill of 4-word lines.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_dm #(
  parameter int NUM_LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {COMPARE, ALLOCATE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [127:0]         data_mem [NUM_LINES];

  logic [1:0]       word;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [127:0]     line;
  logic             hit, miss, fill;
  logic             stall, mem_rd;
  logic             unused_addr_bits;

  assign word  = bus.proc_addr[3:2];
  assign index = bus.proc_addr[4 +: IDX_W];
  assign tag   = bus.proc_addr[31 -: TAG_W];
  assign line  = data_mem[index];
  assign unused_addr_bits = ^bus.proc_addr[1:0];

  assign hit  = bus.proc_read && (state_reg == COMPARE) && valid_reg[index]
                && (tag_mem[index] == tag);
  assign miss = bus.proc_read && (state_reg == COMPARE) && !hit;
  // Reset takes priority over a fill landing in the same cycle.
  assign fill = (state_reg == ALLOCATE) && bus.mem_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= COMPARE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    mem_rd     = 1'b0;
    case (state_reg)
      COMPARE: begin
        if (miss) begin
          stall      = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall  = 1'b1;
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          state_next = COMPARE;
        end
      end
      default: state_next = COMPARE;
    endcase
    if (rst) begin
      stall  = 1'b0;
      mem_rd = 1'b0;
    end
  end

  assign bus.proc_stall = stall;
  assign bus.mem_read   = mem_rd;
  assign bus.mem_addr   = bus.proc_addr[31:4];
  assign bus.proc_rdata = line[{word, 5'b00000} +: 32];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill && (index == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[index] <= bus.mem_rdata;
      tag_mem[index]  <= tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hits_reg, misses_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_reg   <= 32'd0;
      misses_reg <= 32'd0;
    end else begin
      if (hit) begin
        hits_reg <= hits_reg + 32'd1;
      end
      if (miss) begin
        misses_reg <= misses_reg + 32'd1;
      end
    end
  end

  assign perf_hits   = hits_reg;
  assign perf_misses = misses_reg;
`else
  assign perf_hits   = 32'd0;
  assign perf_misses = 32'd0;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: vector table of fetches, memory model, scoreboard, reset corners.
module tb_icache_dm;
  logic        clk;
  logic        rst;
  logic [31:0] perf_hits, perf_misses;

  icache_dm_if bus ();

  icache_dm #(.NUM_LINES(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          stalls;
    logic [27:0] maddr;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;

  // Memory model state
  int mem_lat  = 1;
  bit mem_auto = 1'b1;
  int cyc_cnt  = 0;
  int kick_at  = -1;

  // Every memory word holds its own byte address.
  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) begin
      r[32*w +: 32] = {a, w[1:0], 2'b00};
    end
    return r;
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc_cnt++;
      bus.mem_ready = 1'b0;
      if (cyc_cnt == kick_at) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = line_of(bus.mem_addr);
        cnt = 0;
      end else if (rst || !bus.mem_read || !mem_auto) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = line_of(bus.mem_addr);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_perf(input string nm);
`ifdef ICACHE_PERF_EN
    check({nm, "_hits"}, perf_hits, 32'(exp_hits));
    check({nm, "_misses"}, perf_misses, 32'(exp_misses));
`else
    check({nm, "_hits"}, perf_hits, 32'd0);
    check({nm, "_misses"}, perf_misses, 32'd0);
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the data is delivered.
  task automatic do_fetch(input logic [31:0] addr, input int lat, input int exp_stalls,
                          input logic [27:0] exp_maddr, input string nm);
    int          stalls = 0;
    int          cyc = 0;
    bit          done = 1'b0;
    bit          maddr_ok = 1'b1;
    bit          saw_mr = 1'b0;
    logic [31:0] exp;
    mem_lat = lat;
    bus.proc_read = 1'b1;
    bus.proc_addr = addr;
    exp_q.push_back(addr & 32'hFFFF_FFFC);
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (bus.proc_stall) begin
        stalls++;
        if (bus.mem_read) begin
          saw_mr = 1'b1;
          if (bus.mem_addr !== exp_maddr) maddr_ok = 1'b0;
        end
      end else begin
        exp = exp_q.pop_front();
        check({nm, "_rdata"}, bus.proc_rdata, exp);
        check({nm, "_memread_idle"}, 32'(bus.mem_read), 32'd0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no data within 40 cycles, required data", nm);
    end
    check({nm, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    if (exp_stalls > 0) begin
      check({nm, "_mem_addr_ok"}, 32'(maddr_ok && saw_mr), 32'd1);
      exp_misses++;
    end
    exp_hits++;
    bus.proc_read = 1'b0;
    $display("fetch %s addr=0x%08h data=0x%08h stalls=%0d", nm, addr, bus.proc_rdata, stalls);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0004, 3, 4, 28'h000_0000};
    vecs[1]  = '{32'h0000_0000, 0, 0, 28'h000_0000};
    vecs[2]  = '{32'h0000_0008, 0, 0, 28'h000_0000};
    vecs[3]  = '{32'h0000_000C, 0, 0, 28'h000_0000};
    vecs[4]  = '{32'h0000_0080, 1, 2, 28'h000_0008};
    vecs[5]  = '{32'h0000_0000, 2, 3, 28'h000_0000};
    vecs[6]  = '{32'h0000_0084, 5, 6, 28'h000_0008};
    vecs[7]  = '{32'h1234_5678, 2, 3, 28'h123_4567};
    vecs[8]  = '{32'h1234_567C, 0, 0, 28'h000_0000};
    vecs[9]  = '{32'h0000_0070, 1, 2, 28'h000_0007};
    vecs[10] = '{32'h1234_5670, 1, 2, 28'h123_4567};
    vecs[11] = '{32'h1234_5674, 0, 0, 28'h000_0000};
    vecs[12] = '{32'hFFFF_FFF0, 1, 2, 28'hFFF_FFFF};
    vecs[13] = '{32'hFFFF_FFFF, 0, 0, 28'h000_0000};
    vecs[14] = '{32'h0000_0089, 0, 0, 28'h000_0000};

    rst = 1'b1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 32'h0000_0004;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_stall", 32'(bus.proc_stall), 32'd0);
    check("reset_memread", 32'(bus.mem_read), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.proc_read = 1'b0;
    @(negedge clk);
    check_perf("reset_perf");
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      do_fetch(vecs[i].addr, vecs[i].lat, vecs[i].stalls, vecs[i].maddr, $sformatf("vec%0d", i));
      if (i == 3) check_perf("cold_and_hits_perf");
    end
    check_perf("table_perf");

    for (int i = 0; i < 20; i++) begin
      bus.proc_read = 1'b0;
      bus.proc_addr = $urandom;
      @(negedge clk);
      check("idle_stall", 32'(bus.proc_stall), 32'd0);
      check("idle_memread", 32'(bus.mem_read), 32'd0);
      @(posedge clk);
      #1;
    end
    do_fetch(32'hFFFF_FFF8, 0, 0, 28'h0, "after_idle");
    check_perf("idle_perf");

    // Miss on 0x40, reset during ALLOCATE together with a mem_ready, then a stray mem_ready.
    mem_auto = 1'b0;
    bus.proc_read = 1'b1;
    bus.proc_addr = 32'h0000_0040;
    @(negedge clk);
    check("rstfill_miss_stall", 32'(bus.proc_stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstfill_memread", 32'(bus.mem_read), 32'd1);
    check("rstfill_mem_addr", 32'(bus.mem_addr), 32'h4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.proc_read = 1'b0;
    kick_at = cyc_cnt + 1;
    @(negedge clk);
    check("rst_forces_stall", 32'(bus.proc_stall), 32'd0);
    check("rst_forces_memread", 32'(bus.mem_read), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    kick_at = cyc_cnt + 3;
    exp_hits = 0;
    exp_misses = 0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_stall", 32'(bus.proc_stall), 32'd0);
      check("post_rst_memread", 32'(bus.mem_read), 32'd0);
      @(posedge clk);
      #1;
    end
    check_perf("post_rst_perf");
    mem_auto = 1'b1;
    do_fetch(32'h0000_0040, 2, 3, 28'h000_0004, "refetch_40");
    check_perf("final_perf");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
